psum_acc_ctrl: RTL and testbench
================================

Name: psum_acc_ctrl

Overview:
- Sequences one PE's 32-entry partial-sum scratchpad: accumulate, drain, clear.
- Accepts a stream of signed 16-bit products tagged with a psum index, then performs a single-cycle read-modify-write into the spad. This uses the spad's combinational read port plus a registered write on the same cycle.
- After a configured number of accumulation passes, drains all entries in index order to the downstream psum path, then clears the spad.
- Sits between the PE MAC and the psum spad, and drives every spad control pin.

Parameters:
- DEPTH, 32, number of psum entries (8x4 output tile)
- IDX_W, 5, index width, log2(DEPTH)
- PROD_W, 16, product width (8b iact x 8b weight)
- PSUM_W, 21, psum/accumulator width
- PASS_W, 3, width of pass-count config
- MAX_PASSES, 6, largest legal pass count (2 clusters x 3 PE rows)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- start  in  1  begin a job; sampled in IDLE only
- cfg_passes  in  PASS_W  passes per job; latched on start
- prod_valid  in  1  product valid
- prod_ready  out  1  product accepted
- prod_data  in  PROD_W  signed product
- prod_idx  in  IDX_W  target psum entry
- prod_last  in  1  last product of current pass
- spad_read_idx  out  IDX_W  spad read address
- spad_write_idx  out  IDX_W  spad write address
- spad_psum_in  out  PSUM_W  spad write data
- spad_psum_in_valid  out  1  spad write strobe
- spad_psum_in_ready  in  1  spad write ready
- spad_psum_out  in  PSUM_W  spad combinational read data
- spad_psum_out_ready  out  1  spad read-mode select
- spad_clear  out  1  spad synchronous clear
- out_valid  out  1  drained psum valid
- out_ready  in  1  downstream ready
- out_data  out  PSUM_W  drained psum
- out_idx  out  IDX_W  index of drained psum
- out_last  out  1  asserted with entry DEPTH-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on CLEAR->IDLE after a job

Behaviour:
- States: INIT, CLEAR, IDLE, ACCUM, DRAIN.
- Reset values: state=INIT, pass_cnt=0, drain_idx=0, all outputs 0. The spad is not reset by this block's reset.
- INIT: unconditional -> CLEAR, which guarantees a zeroed spad after every reset, including a reset mid-job.
- CLEAR: spad_clear=1 for exactly one cycle -> IDLE. done=1 that cycle only if entered from DRAIN.
- IDLE, start=1:
  - Latch passes = (cfg_passes==0 ? 1 : min(cfg_passes, MAX_PASSES)).
  - pass_cnt=0; -> ACCUM.
  - start while busy is ignored.
- ACCUM:
  - Drive spad_psum_out_ready=0; prod_ready = spad_psum_in_ready.
  - spad_read_idx = spad_write_idx = prod_idx.
  - spad_psum_in = spad_psum_out + sign-extend(prod_data).
  - spad_psum_in_valid = prod_valid.
  - Latency is zero: the write completes at the accepting edge. Back-to-back products to the same index accumulate correctly because each read sees the prior edge's write.
  - prod_last handshake: if pass_cnt == passes-1 -> DRAIN with drain_idx=0; else pass_cnt++.
- DRAIN:
  - prod_ready=0; spad_psum_in_valid=0; spad_psum_out_ready=1.
  - spad_read_idx = drain_idx; out_valid=1; out_data = spad_psum_out; out_idx = drain_idx; out_last = (drain_idx == DEPTH-1).
  - On out_valid & out_ready: drain_idx++.
  - On out_last handshake: -> CLEAR.
  - Stalled out_ready holds all outputs stable.
- Arithmetic: two's-complement. Without the optional feature, the sum wraps modulo 2^PSUM_W.
- Boundaries:
  - prod_valid outside ACCUM is not accepted.
  - prod_last on pass 0 with passes=1 goes directly to DRAIN.
  - DEPTH-1 drain wraps drain_idx to 0.

Optional Feature:
- PSUM_SAT_EN defined:
  - Accumulation saturates to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - Adds output sat_flag: sticky per job, set on any clamp, cleared on start, reset 0.
- Undefined: wrap-around add; no sat_flag port.

Decomposition:
- Shared package psum_pkg:
  - DEPTH, IDX_W, PROD_W, PSUM_W, MAX_PASSES.
  - State enum encoding (INIT=0, CLEAR=1, IDLE=2, ACCUM=3, DRAIN=4).
- One natural sub-module, psum_acc_adder: sign-extend, add, optional saturation and clamp flag. Purely combinational.
- FSM and counters stay in psum_acc_ctrl.

Test Plan:
- Reset release -> spad_clear high exactly 1 cycle, 1 cycle after INIT; then IDLE, busy=0, done=0.
- start, cfg_passes=1; products 100 @idx3, -40 @idx3, 7 @idx31 (last) -> drain 32 entries: idx3=60, idx31=7, others 0; out_last with idx31; done pulse; spad cleared.
- cfg_passes=6; each pass writes 1000 @idx0 with prod_last -> DRAIN only after the 6th last; out_data[0]=6000.
- Drain with out_ready toggling 1010... -> each index emitted exactly once, in order, data stable while stalled.
- Reset asserted mid-ACCUM after 5 products -> outputs 0 immediately; after release, spad_clear pulses; next job drains all-zero except new products.
- PSUM_SAT_EN: 40 products of 32767 @idx5 -> out_data[5]=1048575, sat_flag=1. Without the macro, out_data[5]=1310680-2097152=-786472.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared constants, FSM state encoding and pass-count clipping for the psum accumulator controller.
package psum_pkg;

    localparam int DEPTH      = 32;
    localparam int IDX_W      = 5;
    localparam int PROD_W     = 16;
    localparam int PSUM_W     = 21;
    localparam int PASS_W     = 3;
    localparam int MAX_PASSES = 6;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_IDLE  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // A zero request still runs one pass; anything above the array limit is capped.
    function automatic logic [PASS_W-1:0] clip_passes(input logic [PASS_W-1:0] cfg);
        if (cfg == '0)
            return PASS_W'(1);
        if (cfg > PASS_W'(MAX_PASSES))
            return PASS_W'(MAX_PASSES);
        return cfg;
    endfunction

endpackage

// File: rtl/psum_acc_adder.sv
// Combinational psum update: sign-extend the product and add it to the stored psum.
// With PSUM_SAT_EN defined the sum clamps to the psum range and reports the clamp.
module psum_acc_adder
    import psum_pkg::*;
(
    input  logic signed [PSUM_W-1:0] psum,
    input  logic signed [PROD_W-1:0] prod,
`ifdef PSUM_SAT_EN
    output logic                     clamp,
`endif
    output logic signed [PSUM_W-1:0] sum
);

`ifdef PSUM_SAT_EN
    localparam int EXT_W = PSUM_W + 1;

    logic signed [EXT_W-1:0] wide;

    // One guard bit is enough: a 16-bit product cannot move a 21-bit value past two ranges.
    function automatic logic signed [PSUM_W-1:0] sat_psum(input logic signed [EXT_W-1:0] v);
        if (v[EXT_W-1] != v[EXT_W-2])
            return v[EXT_W-1] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        return v[PSUM_W-1:0];
    endfunction

    assign wide  = EXT_W'(psum) + EXT_W'(prod);
    assign clamp = wide[EXT_W-1] != wide[EXT_W-2];
    assign sum   = sat_psum(wide);
`else
    assign sum = psum + PSUM_W'(prod);
`endif

endmodule

// File: rtl/psum_acc_ctrl.sv
// Partial-sum scratchpad sequencer: accumulate products for N passes, drain all entries, clear.
// Optional build macro PSUM_SAT_EN selects saturating accumulation and adds the sat_flag output.
module psum_acc_ctrl
    import psum_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PASS_W-1:0]        cfg_passes,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic [IDX_W-1:0]         prod_idx,
    input  logic                     prod_last,
    output logic [IDX_W-1:0]         spad_read_idx,
    output logic [IDX_W-1:0]         spad_write_idx,
    output logic signed [PSUM_W-1:0] spad_psum_in,
    output logic                     spad_psum_in_valid,
    input  logic                     spad_psum_in_ready,
    input  logic signed [PSUM_W-1:0] spad_psum_out,
    output logic                     spad_psum_out_ready,
    output logic                     spad_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PSUM_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
`ifdef PSUM_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     busy,
    output logic                     done
);

    state_t             state;
    logic [PASS_W-1:0]  passes;
    logic [PASS_W-1:0]  pass_cnt;
    logic [IDX_W-1:0]   drain_idx;

    logic               in_accum;
    logic               in_drain;
    logic               prod_hs;
    logic               drain_hs;
    logic signed [PSUM_W-1:0] acc_sum;
`ifdef PSUM_SAT_EN
    logic               clamp;
`endif

    assign in_accum = state == ST_ACCUM;
    assign in_drain = state == ST_DRAIN;

    psum_acc_adder u_adder (
        .psum  (spad_psum_out),
        .prod  (prod_data),
`ifdef PSUM_SAT_EN
        .clamp (clamp),
`endif
        .sum   (acc_sum)
    );

    // Read-modify-write happens in one cycle: the spad read port is combinational and
    // the write lands on the accepting edge, so the next product already sees it.
    assign prod_ready          = in_accum & spad_psum_in_ready;
    assign prod_hs             = prod_valid & prod_ready;
    assign spad_psum_in_valid  = in_accum & prod_valid;
    assign spad_write_idx      = in_accum ? prod_idx : '0;
    assign spad_psum_in        = in_accum ? acc_sum : '0;
    assign spad_read_idx       = in_accum ? prod_idx : (in_drain ? drain_idx : '0);
    assign spad_psum_out_ready = in_drain;

    assign out_valid = in_drain;
    assign out_data  = in_drain ? spad_psum_out : '0;
    assign out_idx   = in_drain ? drain_idx : '0;
    assign out_last  = in_drain && (drain_idx == IDX_W'(DEPTH - 1));
    assign drain_hs  = in_drain & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            passes     <= '0;
            pass_cnt   <= '0;
            drain_idx  <= '0;
            spad_clear <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
`ifdef PSUM_SAT_EN
            sat_flag   <= 1'b0;
`endif
        end else begin
            spad_clear <= 1'b0;
            done       <= 1'b0;
            case (state)
                // Every reset passes through CLEAR so a job aborted mid-way leaves no residue.
                ST_INIT: begin
                    state      <= ST_CLEAR;
                    spad_clear <= 1'b1;
                    busy       <= 1'b1;
                end
                ST_CLEAR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_IDLE: begin
                    if (start) begin
                        passes   <= clip_passes(cfg_passes);
                        pass_cnt <= '0;
                        state    <= ST_ACCUM;
                        busy     <= 1'b1;
`ifdef PSUM_SAT_EN
                        sat_flag <= 1'b0;
`endif
                    end
                end
                ST_ACCUM: begin
                    if (prod_hs) begin
`ifdef PSUM_SAT_EN
                        sat_flag <= sat_flag | clamp;
`endif
                        if (prod_last) begin
                            if (pass_cnt == passes - PASS_W'(1)) begin
                                state     <= ST_DRAIN;
                                drain_idx <= '0;
                            end else begin
                                pass_cnt <= pass_cnt + PASS_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_hs) begin
                        drain_idx <= drain_idx + IDX_W'(1);
                        if (out_last) begin
                            state      <= ST_CLEAR;
                            spad_clear <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_INIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Randomized scoreboard bench for psum_acc_ctrl with a behavioural scratchpad and psum reference model.
`timescale 1ns/1ps
module tb_psum_acc_ctrl;
    import psum_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic                     start = 1'b0;
    logic [PASS_W-1:0]        cfg_passes = '0;
    logic                     prod_valid = 1'b0;
    logic                     prod_ready;
    logic signed [PROD_W-1:0] prod_data = '0;
    logic [IDX_W-1:0]         prod_idx = '0;
    logic                     prod_last = 1'b0;
    logic [IDX_W-1:0]         spad_read_idx;
    logic [IDX_W-1:0]         spad_write_idx;
    logic signed [PSUM_W-1:0] spad_psum_in;
    logic                     spad_psum_in_valid;
    logic                     spad_psum_in_ready = 1'b1;
    logic signed [PSUM_W-1:0] spad_psum_out;
    logic                     spad_psum_out_ready;
    logic                     spad_clear;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [PSUM_W-1:0] out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;
    logic                     busy;
    logic                     done;
`ifdef PSUM_SAT_EN
    logic                     sat_flag;
`endif

    psum_acc_ctrl dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .cfg_passes          (cfg_passes),
        .prod_valid          (prod_valid),
        .prod_ready          (prod_ready),
        .prod_data           (prod_data),
        .prod_idx            (prod_idx),
        .prod_last           (prod_last),
        .spad_read_idx       (spad_read_idx),
        .spad_write_idx      (spad_write_idx),
        .spad_psum_in        (spad_psum_in),
        .spad_psum_in_valid  (spad_psum_in_valid),
        .spad_psum_in_ready  (spad_psum_in_ready),
        .spad_psum_out       (spad_psum_out),
        .spad_psum_out_ready (spad_psum_out_ready),
        .spad_clear          (spad_clear),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_idx             (out_idx),
        .out_last            (out_last),
`ifdef PSUM_SAT_EN
        .sat_flag            (sat_flag),
`endif
        .busy                (busy),
        .done                (done)
    );

    always #5 clock = ~clock;

    // Behavioural scratchpad: combinational read, registered write, synchronous clear, no reset.
    logic signed [PSUM_W-1:0] spad_mem [DEPTH];
    logic scramble = 1'b1;
    always @(posedge clock) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) spad_mem[i] <= PSUM_W'($urandom);
        end else if (spad_clear) begin
            for (int i = 0; i < DEPTH; i++) spad_mem[i] <= '0;
        end else if (spad_psum_in_valid && spad_psum_in_ready) begin
            spad_mem[spad_write_idx] <= spad_psum_in;
        end
    end
    assign spad_psum_out = spad_mem[spad_read_idx];

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: psum values kept as plain integers, wrapped or clamped to the psum range.
    localparam longint MODV = longint'(1) << PSUM_W;
    localparam longint HALF = MODV / 2;
    longint ref_mem [DEPTH];
    bit     ref_sat;

    task automatic apply_model(input int idx, input int data);
        longint s;
        s = ref_mem[idx] + longint'(data);
`ifdef PSUM_SAT_EN
        if (s > HALF - 1) begin s = HALF - 1; ref_sat = 1'b1; end
        else if (s < -HALF) begin s = -HALF; ref_sat = 1'b1; end
`else
        s = ((s + HALF) % MODV + MODV) % MODV - HALF;
`endif
        ref_mem[idx] = s;
    endtask

    function automatic int eff_passes(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > MAX_PASSES) return MAX_PASSES;
        return cfg;
    endfunction

    typedef struct {
        int     idx;
        longint data;
        bit     last;
    } exp_t;
    exp_t exp_q[$];

    int done_cnt  = 0;
    int clear_cnt = 0;
    int in_ready_mode  = 0;
    int out_ready_mode = 0;

    // Ready generators: 0 = always ready, 1 = alternate 1010..., 2 = random.
    initial begin
        forever begin
            @(posedge clock); #1;
            case (in_ready_mode)
                1:       spad_psum_in_ready = ~spad_psum_in_ready;
                2:       spad_psum_in_ready = 1'($urandom_range(0, 1));
                default: spad_psum_in_ready = 1'b1;
            endcase
            case (out_ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every drain handshake and checks stalled outputs hold.
    initial begin
        logic                     held;
        logic signed [PSUM_W-1:0] hd;
        logic [IDX_W-1:0]         hi;
        logic                     hl;
        exp_t                     e;
        held = 1'b0;
        hd = '0; hi = '0; hl = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hd);
                check("stall_idx", out_idx, hi);
                check("stall_last", out_last, hl);
            end
            held = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check("out_expected", exp_q.size() > 0, 1);
                    check("drain_read_mode", spad_psum_out_ready, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("drain_idx", out_idx, e.idx);
                        check("drain_data", out_data, e.data);
                        check("drain_last", out_last, e.last);
                    end
                end else begin
                    held = 1'b1;
                    hd = out_data; hi = out_idx; hl = out_last;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_clear", spad_clear, 1);
            end
            if (spad_clear) clear_cnt++;
        end
    end

    task automatic reset_and_check();
        reset = 1'b0;
        prod_valid = 1'b0;
        start = 1'b0;
        #1;
        check("rst_prod_ready", prod_ready, 0);
        check("rst_spad_in_valid", spad_psum_in_valid, 0);
        check("rst_spad_clear", spad_clear, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_read_mode", spad_psum_out_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef PSUM_SAT_EN
        check("rst_sat_flag", sat_flag, 0);
`endif
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("init_no_clear", spad_clear, 0);
        @(negedge clock);
        check("clear_pulse", spad_clear, 1);
        check("clear_no_done", done, 0);
        @(negedge clock);
        check("clear_one_cycle", spad_clear, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        @(posedge clock); #1;
    endtask

    task automatic start_job(input int cfg, input int in_mode, input int out_mode);
        int n;
        n = 0;
        while (busy && n < 200) begin @(posedge clock); #1; n++; end
        check("idle_before_start", busy, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        ref_sat = 1'b0;
        in_ready_mode  = in_mode;
        out_ready_mode = out_mode;
        start = 1'b1;
        cfg_passes = PASS_W'(cfg);
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_in_job", busy, 1);
    endtask

    // Leaves prod_valid high so consecutive calls stream back-to-back products.
    task automatic send_prod(input int idx, input int data, input bit last);
        int n;
        n = 0;
        prod_valid = 1'b1;
        prod_idx   = IDX_W'(idx);
        prod_data  = PROD_W'(data);
        prod_last  = last;
        start      = ($urandom_range(0, 3) == 0);
        cfg_passes = PASS_W'($urandom);
        forever begin
            @(negedge clock);
            if (prod_ready || n >= 300) break;
            n++;
        end
        if (prod_ready) begin
            check("wr_idx", spad_write_idx, idx);
            check("wr_strobe", spad_psum_in_valid, 1);
            apply_model(idx, data);
        end else begin
            check("prod_accept", prod_ready, 1);
        end
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic end_job();
        int d0, c0, n;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back('{i, ref_mem[i], i == DEPTH - 1});
        d0 = done_cnt;
        c0 = clear_cnt;
        n = 0;
        while (done_cnt == d0 && n < 400) begin @(posedge clock); n++; end
        repeat (3) @(posedge clock);
        #1;
        check("done_pulses", done_cnt - d0, 1);
        check("clear_pulses", clear_cnt - c0, 1);
        check("drain_complete", exp_q.size(), 0);
        check("idle_after_job", busy, 0);
        n = 0;
        for (int i = 0; i < DEPTH; i++) if (spad_mem[i] != 0) n++;
        check("spad_cleared", n, 0);
`ifdef PSUM_SAT_EN
        check("sat_flag", sat_flag, ref_sat);
`endif
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_idx, idx, np, nprod, cfg;
        @(posedge clock); #1;
        scramble = 1'b0;
        reset_and_check();

        // Products offered in IDLE must be refused.
        prod_valid = 1'b1;
        prod_idx = 5'd4;
        prod_data = 16'sd9;
        @(negedge clock);
        check("idle_prod_ready", prod_ready, 0);
        check("idle_spad_strobe", spad_psum_in_valid, 0);
        @(posedge clock); #1;
        prod_valid = 1'b0;

        start_job(1, 0, 0);
        send_prod(3, 100, 1'b0);
        send_prod(3, -40, 1'b0);
        send_prod(31, 7, 1'b1);
        end_job();

        start_job(6, 2, 1);
        for (int p = 0; p < 6; p++) send_prod(0, 1000, 1'b1);
        end_job();

        start_job(0, 1, 2);
        send_prod(9, -32768, 1'b0);
        send_prod(9, -32768, 1'b1);
        end_job();

        start_job(1, 0, 0);
        for (int k = 0; k < 40; k++) send_prod(5, 32767, k == 39);
        end_job();

        // Abort a job mid-accumulation: its products must not survive the reset.
        start_job(3, 0, 0);
        for (int k = 0; k < 5; k++) send_prod(k * 3, 500 + k, 1'b0);
        reset_and_check();
        start_job(1, 0, 1);
        send_prod(3, 11, 1'b0);
        send_prod(20, -22, 1'b1);
        end_job();

        for (int j = 0; j < 8; j++) begin
            cfg = $urandom_range(0, 7);
            start_job(cfg, $urandom_range(0, 2), $urandom_range(0, 2));
            np = eff_passes(cfg);
            last_idx = 0;
            for (int p = 0; p < np; p++) begin
                nprod = $urandom_range(1, 8);
                for (int k = 0; k < nprod; k++) begin
                    idx = ($urandom_range(0, 9) < 3) ? last_idx : int'($urandom_range(0, DEPTH - 1));
                    last_idx = idx;
                    send_prod(idx, int'($urandom_range(0, 65535)) - 32768, k == nprod - 1);
                end
            end
            end_job();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
